// File: rtl/data_mem_burst_reader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_mem_burst_reader_pkg                                      |
// | Purpose  : Shared defaults and FSM state encoding for the data memory    |
// |            burst read engine and its bus interface.                      |
// | Contents : c_DATA_WIDTH / c_ADDR_WIDTH / c_MEM_SIZE / c_LEN_WIDTH        |
// |            default sizes (the same values data_mem uses), state_t enum.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package data_mem_burst_reader_pkg;

  localparam int unsigned c_DATA_WIDTH = 16;
  localparam int unsigned c_ADDR_WIDTH = 16;
  localparam int unsigned c_MEM_SIZE   = 256;
  localparam int unsigned c_LEN_WIDTH  = 9;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BURST      = 2'd1,
    ST_DRAIN      = 2'd2,
    ST_DONE_EMPTY = 2'd3
  } state_t;

endpackage : data_mem_burst_reader_pkg
`default_nettype wire

// File: rtl/data_mem_burst_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_mem_burst_reader_if                                       |
// | Purpose  : Bundles the request handshake, the memory read port and the  |
// |            output stream of the burst read engine.                       |
// | Signals  : req_valid/req_ready/req_addr/req_len   burst request          |
// |            mem_rd_addr/mem_rd_data                 combinational mem read |
// |            out_valid/out_ready/out_data/out_last  output beat stream     |
// |            busy/done                               engine status          |
// | Modports : slave  - the engine (data_mem_burst_reader)                   |
// |            master - requester, memory model and consumer                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface data_mem_burst_reader_if
  import data_mem_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = c_LEN_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;

  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  logic                  busy;
  logic                  done;

  modport slave (
    input  req_valid, req_addr, req_len, mem_rd_data, out_ready,
    output req_ready, mem_rd_addr, out_valid, out_data, out_last, busy, done
  );

  modport master (
    output req_valid, req_addr, req_len, mem_rd_data, out_ready,
    input  req_ready, mem_rd_addr, out_valid, out_data, out_last, busy, done
  );

endinterface : data_mem_burst_reader_if
`default_nettype wire

// File: rtl/data_mem_burst_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_mem_burst_reader                                          |
// | Purpose  : Read-side engine for data_mem. Accepts (start address,       |
// |            length) bursts and streams the words out over valid/ready,   |
// |            flagging the final beat with out_last.                        |
// | Ports    : clk  - clock, all logic on posedge                            |
// |            rst  - synchronous active-high reset                          |
// |            bus  - data_mem_burst_reader_if.slave: request handshake,     |
// |                   memory read port, output stream, busy/done status      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module data_mem_burst_reader
  import data_mem_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH,
  parameter int unsigned MEM_SIZE   = c_MEM_SIZE,   // power of two
  parameter int unsigned LEN_WIDTH  = c_LEN_WIDTH
) (
  input wire logic              clk,
  input wire logic              rst,
  data_mem_burst_reader_if.slave bus
);

  // MEM_SIZE is a power of two, so wrapping is a simple mask.
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_MASK = ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                state_q;
  logic                  req_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;

  logic                  w_slot_free;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  // The output register can take a new word when empty or when its current
  // beat is being consumed this cycle.
  assign w_slot_free = !out_valid_q || bus.out_ready;
  assign w_addr_next = (cur_addr_q + ADDR_WIDTH'(1)) & c_ADDR_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // req_ready_q is high throughout IDLE, so req_valid alone accepts.
          if (bus.req_valid) begin
            cur_addr_q  <= bus.req_addr & c_ADDR_MASK;
            remaining_q <= bus.req_len;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= (bus.req_len == '0) ? ST_DONE_EMPTY : ST_BURST;
          end
        end

        ST_BURST: begin
          if (w_slot_free) begin
            out_data_q  <= bus.mem_rd_data;
            out_valid_q <= 1'b1;
            out_last_q  <= (remaining_q == LEN_WIDTH'(1));
            cur_addr_q  <= w_addr_next;
            remaining_q <= remaining_q - LEN_WIDTH'(1);
            // Loading stops at the final word, so remaining never wraps.
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_q <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        ST_DONE_EMPTY: begin
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Read address tracks cur_addr in every state, so the memory never sees X.
  assign bus.mem_rd_addr = cur_addr_q;
  assign bus.req_ready   = req_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule : data_mem_burst_reader
`default_nettype wire

// File: tb/tb_data_mem_burst_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_mem_burst_reader                                       |
// | Purpose  : Self-checking bench for data_mem_burst_reader. Stimulus       |
// |            pushes expected beats into a scoreboard queue; a monitor     |
// |            pops and compares on every output handshake, and also        |
// |            checks done timing and beat stability under backpressure.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_data_mem_burst_reader;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic clk;
  logic rst;
  logic mon_en;
  logic toggle_en;
  int   cyc;
  int   empty_done_cyc;
  int   vectors;
  int   miscompares;

  beat_t       exp_q[$];
  logic [15:0] mem [256];

  data_mem_burst_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .LEN_WIDTH(9)) bus ();

  data_mem_burst_reader #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .MEM_SIZE  (256),
    .LEN_WIDTH (9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Combinational memory model.
  assign bus.mem_rd_data = mem[bus.mem_rd_addr[7:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // out_ready driver: held high unless the 1,0,0,1 backpressure pattern is enabled.
  initial begin
    logic [3:0] pat;
    int         idx;
    pat = 4'b1001;
    idx = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) begin
        bus.out_ready = pat[idx];
        idx = (idx + 1) % 4;
      end else begin
        bus.out_ready = 1'b1;
        idx = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        prev_stall;
    logic        prev_last_hs;
    logic [15:0] prev_data;
    logic        prev_last;
    logic        hs;
    logic        exp_done;
    beat_t       b;
    prev_stall   = 1'b0;
    prev_last_hs = 1'b0;
    prev_data    = '0;
    prev_last    = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", 32'(bus.out_valid), 32'd1);
          check("stall_data_stable", 32'(bus.out_data), 32'(prev_data));
          check("stall_last_stable", 32'(bus.out_last), 32'(prev_last));
        end
        exp_done = prev_last_hs || (cyc == empty_done_cyc);
        check("done_pulse", 32'(bus.done), 32'(exp_done));
        hs = bus.out_valid && bus.out_ready;
        if (hs) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got data 0x%0h last %0b, want no beat (cycle %0d)",
                     bus.out_data, bus.out_last, cyc);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", 32'(bus.out_data), 32'(b.data));
            check("beat_last", 32'(bus.out_last), 32'(b.last));
          end
        end
        prev_stall   = bus.out_valid && !bus.out_ready;
        prev_data    = bus.out_data;
        prev_last    = bus.out_last;
        prev_last_hs = hs && bus.out_last;
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Presents one request; returns T, the cycle in which it is accepted.
  task automatic issue(input logic [15:0] addr, input logic [8:0] len, output int t);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len;
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    t = cyc;
    if (len == 9'd0) empty_done_cyc = t + 2;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d beats pending busy=%0b, want 0 pending busy=0",
               name, exp_q.size(), bus.busy);
    end
  endtask

  initial begin
    int t;
    int first;
    vectors        = 0;
    miscompares    = 0;
    mon_en         = 1'b0;
    toggle_en      = 1'b0;
    empty_done_cyc = -1;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h5000 + 16'(i);

    // Reset: two cycles of rst, then idle outputs.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_mem_rd_addr", 32'(bus.mem_rd_addr), 32'd0);
    mon_en = 1'b1;

    // Basic 4-beat burst, out_ready held high.
    mem[10] = 16'h00A0; mem[11] = 16'h00A1; mem[12] = 16'h00A2; mem[13] = 16'h00A3;
    push(16'h00A0, 1'b0); push(16'h00A1, 1'b0); push(16'h00A2, 1'b0); push(16'h00A3, 1'b1);
    issue(16'd10, 9'd4, t);
    first = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        first = cyc;
        break;
      end
    end
    check("first_beat_latency", 32'(first), 32'(t + 2));
    wait_idle("burst4");

    // Same burst under 1,0,0,1 backpressure.
    toggle_en = 1'b1;
    push(16'h00A0, 1'b0); push(16'h00A1, 1'b0); push(16'h00A2, 1'b0); push(16'h00A3, 1'b1);
    issue(16'd10, 9'd4, t);
    wait_idle("burst4_bp");
    toggle_en = 1'b0;

    // Address wrap 254 -> 255 -> 0.
    mem[254] = 16'h0011; mem[255] = 16'h0022; mem[0] = 16'h0033;
    push(16'h0011, 1'b0); push(16'h0022, 1'b0); push(16'h0033, 1'b1);
    issue(16'd254, 9'd3, t);
    @(negedge clk);
    check("wrap_rd_addr_0", 32'(bus.mem_rd_addr), 32'd254);
    @(negedge clk);
    check("wrap_rd_addr_1", 32'(bus.mem_rd_addr), 32'd255);
    @(negedge clk);
    check("wrap_rd_addr_2", 32'(bus.mem_rd_addr), 32'd0);
    wait_idle("wrap");

    // Empty burst: no beats, done two cycles after accept.
    issue(16'd5, 9'd0, t);
    @(negedge clk);
    check("empty_busy_t1", 32'(bus.busy), 32'd1);
    check("empty_req_ready_t1", 32'(bus.req_ready), 32'd0);
    check("empty_out_valid_t1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("empty_done_t2", 32'(bus.done), 32'd1);
    check("empty_req_ready_t2", 32'(bus.req_ready), 32'd1);
    check("empty_busy_t2", 32'(bus.busy), 32'd0);
    check("empty_out_valid_t2", 32'(bus.out_valid), 32'd0);
    repeat (2) @(negedge clk);

    // Reset during the second beat of an 8-beat burst.
    for (int i = 0; i < 8; i++) push(16'h5014 + 16'(i), (i == 7));
    issue(16'd20, 9'd8, t);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_last", 32'(bus.out_last), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_done", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);

    // Fresh single-word burst after the reset.
    push(16'h0033, 1'b1);
    issue(16'd0, 9'd1, t);
    wait_idle("post_rst_len1");
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_data_mem_burst_reader
`default_nettype wire
